// File: rtl/lsu.sv
// lsu - load/store unit (MEM stage).
//
// Accepts one operation per valid/ready handshake. Non-memory ops are
// registered straight through to writeback. Aligned loads/stores run one
// req/ack transaction on the data bus. Misaligned memory ops are dropped
// and flagged with a single-cycle misalign_o pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   valid_i/ready_o upstream handshake
//   regcData_i ..   execute-stage operation fields (ALU result, dest reg,
//   wmask_i         writeback controls, memory address/data/enables/masks)
//   bus_*           single-outstanding data bus (req held until ack)
//   wb_*            registered writeback result, wb_valid is a 1-cycle pulse
//   misalign_o      1-cycle pulse when a misaligned access is dropped
//
// State | meaning
// IDLE  | ready for a new operation
// BUS   | bus_req high, waiting for bus_ack
// RESP  | wb_valid pulse for the completed memory op
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] regcData_i,
  input  logic [4:0]  regcAddr_i,
  input  logic        REG_EN_i,
  input  logic [1:0]  WB_SEL_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] memData_i,
  input  logic        readWr_i,
  input  logic        writeWr_i,
  input  logic [3:0]  rmask_i,
  input  logic [3:0]  wmask_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic        wb_en,
  output logic [1:0]  wb_sel,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        accept, is_mem, is_store, is_half, is_word, misalign;
  logic [1:0]  off, off_q;
  logic [3:0]  size_mask, rmask_q;
  logic [31:0] wdata_fmt, rdata_sh, load_res, regc_q;

  assign ready_o   = (state == IDLE);
  // Async reset of the state register drops the request immediately.
  assign bus_req   = (state == BUS);
  assign accept    = valid_i & ready_o;
  // Both enables set is treated as a store.
  assign is_store  = writeWr_i;
  assign is_mem    = readWr_i | writeWr_i;
  assign size_mask = is_store ? wmask_i : rmask_i;
  assign is_word   = size_mask[3];
  assign is_half   = ~size_mask[3] & size_mask[1];
  assign off       = memAddr_i[1:0];
  assign misalign  = (is_half & off[0]) | (is_word & (off != 2'b00));

  always_comb begin
    wdata_fmt = {4{memData_i[7:0]}};
    if (wmask_i[3])      wdata_fmt = memData_i;
    else if (wmask_i[1]) wdata_fmt = {2{memData_i[15:0]}};
  end

  // Bring the addressed lane down to bit 0, then sign-extend by size.
  always_comb begin
    rdata_sh = bus_rdata >> {off_q, 3'b000};
    load_res = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
    if (rmask_q[3])      load_res = bus_rdata;
    else if (rmask_q[1]) load_res = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_mem && !misalign) state_nxt = BUS;
      BUS:  if (bus_ack) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_addr    <= '0;
      wb_en      <= 1'b0;
      wb_sel     <= '0;
      misalign_o <= 1'b0;
      off_q      <= '0;
      rmask_q    <= '0;
      regc_q     <= '0;
    end else begin
      wb_valid   <= 1'b0;
      misalign_o <= 1'b0;
      if (accept) begin
        wb_addr <= regcAddr_i;
        wb_en   <= REG_EN_i;
        wb_sel  <= WB_SEL_i;
        regc_q  <= regcData_i;
        off_q   <= off;
        rmask_q <= rmask_i;
        if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_data  <= regcData_i;
        end else if (misalign) begin
          misalign_o <= 1'b1;
        end else begin
          // Bus fields only change on accept, so they stay stable while in BUS.
          bus_we    <= is_store;
          bus_addr  <= {memAddr_i[31:2], 2'b00};
          bus_wdata <= wdata_fmt;
          bus_wstrb <= is_store ? (wmask_i << off) : 4'b0000;
        end
      end
      if (bus_req && bus_ack) begin
        wb_valid <= 1'b1;
        wb_data  <= bus_we ? regc_q : load_res;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i, ready_o;
  logic [31:0] regcData_i, memAddr_i, memData_i;
  logic [4:0]  regcAddr_i;
  logic        REG_EN_i, readWr_i, writeWr_i;
  logic [1:0]  WB_SEL_i;
  logic [3:0]  rmask_i, wmask_i;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        wb_valid, wb_en, misalign_o;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic [1:0]  wb_sel;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .REG_EN_i(REG_EN_i),
    .WB_SEL_i(WB_SEL_i), .memAddr_i(memAddr_i), .memData_i(memData_i),
    .readWr_i(readWr_i), .writeWr_i(writeWr_i), .rmask_i(rmask_i), .wmask_i(wmask_i),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en),
    .wb_sel(wb_sel), .misalign_o(misalign_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus responder ----------------
  int          fixed_wait = -1;
  bit          fixed_rd_en = 1'b0;
  logic [31:0] fixed_rd = '0;
  bit          spur_en = 1'b0;
  bit          spur_now = 1'b0;
  int          wcnt = 0;
  bit          in_txn = 1'b0;

  initial begin
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (rst) in_txn = 1'b0;
      else if (bus_req) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (wcnt == 0) begin
          bus_ack = 1'b1;
          in_txn  = 1'b0;
          if (fixed_rd_en) bus_rdata = fixed_rd;
        end else wcnt--;
      end else begin
        in_txn = 1'b0;
        if (spur_now || (spur_en && $urandom_range(0, 3) == 0)) bus_ack = 1'b1;
      end
    end
  end

  // ---------------- reference model + compare ----------------
  function automatic logic [31:0] load_val(input logic [31:0] rd, input int o, input int sz);
    logic [31:0] v;
    v = rd >> (8 * o);
    if (sz == 1) return {{24{v[7]}}, v[7:0]};
    if (sz == 2) return {{16{v[15]}}, v[15:0]};
    return rd;
  endfunction

  int          phase = 0;      // 0 ready, 1 bus in flight, 2 result cycle
  bit          p_st;
  int          p_size, p_off;
  logic [31:0] p_addr, p_wdata, p_regc;
  logic [3:0]  p_strb;
  logic [4:0]  p_rd;
  bit          p_en;
  logic [1:0]  p_sel;
  bit          e_wbv = 1'b0, e_mis = 1'b0;
  logic [31:0] e_data;
  logic [4:0]  e_addr;
  bit          e_en;
  logic [1:0]  e_sel;
  int          wb_count = 0;

  initial begin
    bit n_wbv, n_mis, st, mem;
    logic [3:0] m;
    int sz, o;
    forever begin
      @(negedge clk);
      if (wb_valid) wb_count++;
      if (rst) begin
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_misalign", misalign_o, 1'b0);
        phase = 0; e_wbv = 1'b0; e_mis = 1'b0;
      end else begin
        chk1("ready", ready_o, phase == 0);
        chk1("bus_req", bus_req, phase == 1);
        if (phase == 1) begin
          chk("bus_addr", bus_addr, p_addr);
          chk1("bus_we", bus_we, p_st);
          chk("bus_wstrb", 32'(bus_wstrb), 32'(p_strb));
          if (p_st) chk("bus_wdata", bus_wdata, p_wdata);
        end
        chk1("wb_valid", wb_valid, e_wbv);
        if (e_wbv) begin
          chk("wb_data", wb_data, e_data);
          chk("wb_addr", 32'(wb_addr), 32'(e_addr));
          chk1("wb_en", wb_en, e_en);
          chk("wb_sel", 32'(wb_sel), 32'(e_sel));
        end
        chk1("misalign", misalign_o, e_mis);
        n_wbv = 1'b0; n_mis = 1'b0;
        if (phase == 2) phase = 0;
        else if (phase == 1) begin
          if (bus_ack) begin
            phase  = 2;
            n_wbv  = 1'b1;
            e_data = p_st ? p_regc : load_val(bus_rdata, p_off, p_size);
            e_addr = p_rd; e_en = p_en; e_sel = p_sel;
          end
        end else if (valid_i) begin
          st  = writeWr_i;
          mem = readWr_i | writeWr_i;
          m   = st ? wmask_i : rmask_i;
          sz  = (m == 4'b1111) ? 4 : (m == 4'b0011) ? 2 : 1;
          o   = int'(memAddr_i[1:0]);
          if (!mem) begin
            n_wbv  = 1'b1;
            e_data = regcData_i; e_addr = regcAddr_i; e_en = REG_EN_i; e_sel = WB_SEL_i;
          end else if (o % sz != 0) begin
            n_mis = 1'b1;
          end else begin
            phase   = 1;
            p_st    = st;
            p_size  = sz;
            p_off   = o;
            p_addr  = memAddr_i & 32'hFFFF_FFFC;
            p_wdata = (sz == 4) ? memData_i : (sz == 2) ? {2{memData_i[15:0]}} : {4{memData_i[7:0]}};
            p_strb  = st ? 4'(((1 << sz) - 1) << o) : 4'b0000;
            p_regc  = regcData_i; p_rd = regcAddr_i; p_en = REG_EN_i; p_sel = WB_SEL_i;
          end
        end
        e_wbv = n_wbv; e_mis = n_mis;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input bit rd, input bit wr, input logic [31:0] regc, input logic [4:0] ra,
                      input bit en, input logic [1:0] sel, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] rm, input logic [3:0] wm);
    int t;
    valid_i = 1'b1; readWr_i = rd; writeWr_i = wr; regcData_i = regc; regcAddr_i = ra;
    REG_EN_i = en; WB_SEL_i = sel; memAddr_i = addr; memData_i = data;
    rmask_i = rm; wmask_i = wm;
    t = 0;
    @(negedge clk);
    while (!ready_o && t < 100) begin @(negedge clk); t++; end
    if (!ready_o) begin
      chk1("accept_timeout", 1'b0, 1'b1);
      valid_i = 1'b0;
      return;
    end
    sync();
    valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lows, c0, t;
    logic [3:0] masks [3];
    masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b1111;
    valid_i = 0; readWr_i = 0; writeWr_i = 0; regcData_i = 0; regcAddr_i = 0;
    REG_EN_i = 0; WB_SEL_i = 0; memAddr_i = 0; memData_i = 0; rmask_i = 0; wmask_i = 0;

    repeat (2) @(negedge clk);
    chk1("rst_ready", ready_o, 1'b1);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
    chk1("rst_bus_we", bus_we, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_addr", 32'(wb_addr), 32'h0);
    chk1("rst_wb_en", wb_en, 1'b0);
    chk("rst_wb_sel", 32'(wb_sel), 32'h0);
    #2 rst = 1'b0;

    // non-memory pass-through
    sync();
    send(0, 0, 32'h12345678, 5'd5, 1, 2'b01, 32'h0, 32'h0, 4'b0, 4'b0);
    @(negedge clk);
    chk1("nm_wb_valid", wb_valid, 1'b1);
    chk("nm_wb_data", wb_data, 32'h12345678);
    chk("nm_wb_addr", 32'(wb_addr), 32'd5);
    chk1("nm_wb_en", wb_en, 1'b1);
    chk1("nm_bus_req", bus_req, 1'b0);

    // byte load with 3 wait cycles
    fixed_wait = 3; fixed_rd_en = 1'b1; fixed_rd = 32'h80FF_0000;
    sync();
    send(1, 0, 32'hAAAA, 5'd7, 1, 2'b10, 32'h0000_1003, 32'h0, 4'b0001, 4'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("lb_bus_req", bus_req, 1'b1);
      chk("lb_bus_addr", bus_addr, 32'h0000_1000);
      chk("lb_bus_wstrb", 32'(bus_wstrb), 32'h0);
    end
    @(negedge clk);
    chk1("lb_wb_valid", wb_valid, 1'b1);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);

    // half store, zero-wait
    fixed_wait = 0; fixed_rd_en = 1'b0;
    sync();
    send(0, 1, 32'h55, 5'd3, 0, 2'b00, 32'h0000_2002, 32'h0000_BEEF, 4'b0, 4'b0011);
    @(negedge clk);
    chk1("sh_bus_we", bus_we, 1'b1);
    chk("sh_bus_wstrb", 32'(bus_wstrb), 32'h0000_000C);
    chk("sh_bus_wdata", bus_wdata, 32'hBEEF_BEEF);
    chk("sh_bus_addr", bus_addr, 32'h0000_2000);
    lows = ready_o ? 0 : 1;
    repeat (3) begin @(negedge clk); if (!ready_o) lows++; end
    chk("sh_ready_low_cycles", 32'(lows), 32'd2);

    // misaligned word load
    sync();
    send(1, 0, 32'h1, 5'd9, 1, 2'b00, 32'h0000_3001, 32'h0, 4'b1111, 4'b0);
    @(negedge clk);
    chk1("mis_pulse", misalign_o, 1'b1);
    chk1("mis_no_req", bus_req, 1'b0);
    chk1("mis_no_wb", wb_valid, 1'b0);
    @(negedge clk);
    chk1("mis_pulse_end", misalign_o, 1'b0);
    chk1("mis_no_req2", bus_req, 1'b0);

    // back-to-back load, non-mem, store with valid held
    fixed_rd_en = 1'b1; fixed_rd = 32'hCAFE_F00D;
    sync();
    c0 = wb_count;
    send(1, 0, 32'h0, 5'd1, 1, 2'b01, 32'h0000_0010, 32'h0, 4'b1111, 4'b0);
    send(0, 0, 32'h1111, 5'd2, 1, 2'b00, 32'h0, 32'h0, 4'b0, 4'b0);
    send(0, 1, 32'h2222, 5'd3, 0, 2'b11, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0, 4'b1111);
    repeat (6) sync();
    chk("b2b_wb_count", 32'(wb_count - c0), 32'd3);

    // reset during a bus transaction
    fixed_wait = 5;
    sync();
    send(1, 0, 32'h0, 5'd4, 1, 2'b00, 32'h0000_0040, 32'h0, 4'b1111, 4'b0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("rst_drops_req", bus_req, 1'b0);
    chk1("rst_ready_now", ready_o, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    sync();
    c0 = wb_count;
    @(negedge clk); spur_now = 1'b1;
    @(negedge clk); spur_now = 1'b0;
    repeat (4) sync();
    chk("rst_no_wb", 32'(wb_count - c0), 32'd0);
    fixed_wait = 1; fixed_rd = 32'h8001_0000;
    send(1, 0, 32'h0, 5'd6, 1, 2'b00, 32'h0000_0052, 32'h0, 4'b0011, 4'b0);
    t = 0;
    @(negedge clk);
    while (!wb_valid && t < 10) begin @(negedge clk); t++; end
    chk1("post_rst_wb_valid", wb_valid, 1'b1);
    chk("post_rst_lh_data", wb_data, 32'hFFFF_8001);

    // randomized traffic
    fixed_wait = -1; fixed_rd_en = 1'b0; spur_en = 1'b1;
    sync();
    for (int n = 0; n < 300; n++) begin
      int kind, gap;
      kind = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(0, 2));
      repeat (gap) sync();
      send(kind == 1 || kind == 3, kind >= 2, $urandom, 5'($urandom), 1'($urandom),
           2'($urandom), $urandom, $urandom,
           masks[$urandom_range(0, 2)], masks[$urandom_range(0, 2)]);
    end
    repeat (10) sync();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
